// File: rtl/xor_nn_pkg.sv
// rtl/xor_nn_pkg.sv - shared constants, state encoding and default weights for the XOR network
//
// Purpose: widths, weight address map, FSM state type and the reset weight set
//          (which computes XOR) shared by the sequencer and its MAC.
// Ports:   none (package).
package xor_nn_pkg;

   localparam int W_W_DEF   = 8;
   localparam int ACC_W_DEF = 18;
   localparam int N_WEIGHTS = 9;
   localparam int RELU_MAX  = 127;

   // Weight map: W1[i][j] at i*2+j (0..5), W2[k] at 6+k (6..8).
   localparam logic [3:0] W1_BASE   = 4'd0;
   localparam logic [3:0] W2_BASE   = 4'd6;
   localparam logic [3:0] LAST_ADDR = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_L1   = 2'd1,
      ST_L2   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // W1 = {0,-1, 1,1, 1,1}, W2 = {0,1,-2}
   function automatic int default_weight(input int addr);
      case (addr)
         1:             return -1;
         2, 3, 4, 5, 7: return 1;
         8:             return -2;
         default:       return 0;
      endcase
   endfunction

endpackage

// File: rtl/xor_nn_mac.sv
// rtl/xor_nn_mac.sv - signed multiply-accumulate with clear and enable
//
// Purpose: single shared MAC; acc <= acc + a*b when en, acc <= 0 when clear.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          clear, en       - clear has priority over accumulate
//          a, b            - signed W_W operands
//          acc             - registered accumulator (ACC_W, signed)
//          sum             - acc + a*b, combinational, for end-of-neuron capture
module xor_nn_mac
   import xor_nn_pkg::*;
#(
   parameter int W_W   = W_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    en,
   input  logic signed [W_W-1:0]   a,
   input  logic signed [W_W-1:0]   b,
   output logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] sum
);

   logic signed [2*W_W-1:0] prod;

   assign prod = a * b;
   assign sum  = acc + ACC_W'(prod);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/xor_nn_sequencer.sv
// rtl/xor_nn_sequencer.sv - two-layer XOR network evaluated term by term on one shared MAC
//
// Purpose: accepts a 2-bit sample {b,a}, runs 6 layer-1 terms and 3 layer-2 terms
//          through xor_nn_mac, and presents score/prediction with a valid/ready handshake.
//          Result is first consumable at the 10th edge after acceptance.
// Ports:   clk, reset                    - clock, synchronous active-high reset
//          in_valid, in_data, in_ready   - sample input handshake
//          out_valid, out_ready          - result handshake
//          out_pred, out_score           - predicted class, signed layer-2 sum
//          wr_en, wr_addr, wr_data       - weight write port (IDLE only, addr 0..8)
//          wr_err                        - one-cycle pulse after a rejected write
//          busy                          - high outside IDLE
module xor_nn_sequencer
   import xor_nn_pkg::*;
#(
   parameter int W_W   = W_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [1:0]              in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_pred,
   output logic signed [ACC_W-1:0] out_score,
   input  logic                    wr_en,
   input  logic [3:0]              wr_addr,
   input  logic [W_W-1:0]          wr_data,
   output logic                    wr_err,
   output logic                    busy
);

   localparam logic signed [W_W-1:0]   ONE_W    = W_W'(1);
   localparam logic signed [ACC_W-1:0] CLAMP_HI = ACC_W'(RELU_MAX);

   state_t                  state, state_n;
   logic [3:0]              step;
   logic                    a_q, b_q;
   logic signed [W_W-1:0]   r0, r1;
   logic signed [W_W-1:0]   weights [N_WEIGHTS];
   logic [3:0]              rd_addr;
   logic signed [W_W-1:0]   mult;
   logic signed [W_W-1:0]   a_ext, b_ext;
   logic                    mac_en, mac_clear;
   logic signed [ACC_W-1:0] acc, sum;
   logic signed [ACC_W-1:0] score_q;
   logic                    pred_q;
   logic                    wr_ok;

   // Clamp on the full accumulator so large positive or any negative sum saturates.
   function automatic logic signed [W_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] v);
      if (v[ACC_W-1])
         return '0;
      else if (v > CLAMP_HI)
         return W_W'(RELU_MAX);
      else
         return v[W_W-1:0];
   endfunction

   assign a_ext = {{(W_W-1){1'b0}}, a_q};
   assign b_ext = {{(W_W-1){1'b0}}, b_q};
   assign wr_ok = wr_en && (state == ST_IDLE) && (wr_addr <= LAST_ADDR);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (in_valid)      state_n = ST_L1;
         ST_L1:   if (step == 4'd5)  state_n = ST_L2;
         ST_L2:   if (step == 4'd2)  state_n = ST_DONE;
         ST_DONE: if (out_ready)     state_n = ST_IDLE;
         default:                    state_n = ST_IDLE;
      endcase
   end

   // Output / control logic
   always_comb begin
      in_ready  = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
      out_valid = (state == ST_DONE);
      mac_en    = (state == ST_L1) || (state == ST_L2);
      // Clear on acceptance and on the last term of each hidden neuron; the clamped
      // sum is captured into r_j on that same edge.
      mac_clear = ((state == ST_IDLE) && in_valid) ||
                  ((state == ST_L1) && ((step == 4'd2) || (step == 4'd5)));
   end

   // Operand selection: L1 walks i fastest within neuron j, L2 walks bias, r0, r1.
   always_comb begin
      rd_addr = W1_BASE;
      mult    = ONE_W;
      if (state == ST_L2) begin
         rd_addr = W2_BASE + step;
         case (step)
            4'd0:    mult = ONE_W;
            4'd1:    mult = r0;
            default: mult = r1;
         endcase
      end else begin
         case (step)
            4'd0:    begin rd_addr = 4'd0; mult = ONE_W; end
            4'd1:    begin rd_addr = 4'd2; mult = a_ext; end
            4'd2:    begin rd_addr = 4'd4; mult = b_ext; end
            4'd3:    begin rd_addr = 4'd1; mult = ONE_W; end
            4'd4:    begin rd_addr = 4'd3; mult = a_ext; end
            default: begin rd_addr = 4'd5; mult = b_ext; end
         endcase
      end
   end

   xor_nn_mac #(
      .W_W   (W_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clear (mac_clear),
      .en    (mac_en),
      .a     (weights[rd_addr]),
      .b     (mult),
      .acc   (acc),
      .sum   (sum)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_WEIGHTS; k++)
            weights[k] <= W_W'(default_weight(k));
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && !wr_ok;
         if (wr_ok)
            weights[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step    <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         r0      <= '0;
         r1      <= '0;
         score_q <= '0;
         pred_q  <= 1'b0;
      end else begin
         if (state_n != state)
            step <= '0;
         else if (mac_en)
            step <= step + 4'd1;
         if ((state == ST_IDLE) && in_valid)
            {b_q, a_q} <= in_data;
         if ((state == ST_L1) && (step == 4'd2))
            r0 <= relu_clamp(sum);
         if ((state == ST_L1) && (step == 4'd5))
            r1 <= relu_clamp(sum);
         if ((state == ST_L2) && (step == 4'd2)) begin
            score_q <= sum;
            pred_q  <= !sum[ACC_W-1] && (sum != '0);
         end
      end
   end

   assign out_score = score_q;
   assign out_pred  = pred_q;

endmodule

// File: tb/tb_xor_nn_sequencer.sv
// tb/tb_xor_nn_sequencer.sv - scoreboard bench for xor_nn_sequencer
module tb_xor_nn_sequencer;

   localparam int W_W   = 8;
   localparam int ACC_W = 18;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    in_valid;
   logic [1:0]              in_data;
   logic                    in_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_pred;
   logic signed [ACC_W-1:0] out_score;
   logic                    wr_en;
   logic [3:0]              wr_addr;
   logic [W_W-1:0]          wr_data;
   logic                    wr_err;
   logic                    busy;

   always #5 clk = ~clk;

   xor_nn_sequencer #(.W_W(W_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pred  (out_pred),
      .out_score (out_score),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_err    (wr_err),
      .busy      (busy)
   );

   typedef struct {
      int score;
      int pred;
   } exp_t;

   exp_t sb[$];
   int   wm[9];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic signed [31:0] got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_defaults();
      wm = '{0, -1, 1, 1, 1, 1, 0, 1, -2};
   endtask

   function automatic int clamp127(input int v);
      if (v < 0)   return 0;
      if (v > 127) return 127;
      return v;
   endfunction

   function automatic exp_t model(input logic [1:0] d);
      int   a, b, h0, h1, s;
      exp_t e;
      a  = int'(d[0]);
      b  = int'(d[1]);
      h0 = wm[0] + a * wm[2] + b * wm[4];
      h1 = wm[1] + a * wm[3] + b * wm[5];
      s  = wm[6] + clamp127(h0) * wm[7] + clamp127(h1) * wm[8];
      e.score = s;
      e.pred  = (s > 0) ? 1 : 0;
      return e;
   endfunction

   task automatic write_w(input int addr, input int data, input int exp_err);
      wr_en   = 1'b1;
      wr_addr = addr[3:0];
      wr_data = data[W_W-1:0];
      @(negedge clk);
      wr_en = 1'b0;
      check("wr_err_pulse", wr_err, exp_err);
      if (exp_err == 0) wm[addr] = data;
      @(negedge clk);
      check("wr_err_clear", wr_err, 0);
   endtask

   // Offers one sample in IDLE; returns at the negedge after the acceptance edge.
   task automatic start(input logic [1:0] d, input logic rdy);
      check("in_ready_idle", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = rdy;
      sb.push_back(model(d));
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
      check("busy_after_accept", busy, 1);
   endtask

   // n0 = index of the current cycle counted from the acceptance edge.
   task automatic collect(input int n0, input int hold);
      int   n;
      exp_t e;
      n = n0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, 10);
      e = sb.pop_front();
      for (int k = 0; k < hold; k++) begin
         check("hold_valid", out_valid, 1);
         check("hold_score", out_score, e.score);
         check("hold_in_ready", in_ready, 0);
         in_valid = 1'b1;
         in_data  = 2'b11;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("out_valid", out_valid, 1);
      check("out_score", out_score, e.score);
      check("out_pred", out_pred, e.pred);
      @(negedge clk);
      check("valid_drop", out_valid, 0);
      check("in_ready_back", in_ready, 1);
   endtask

   task automatic run_sample(input logic [1:0] d, input int hold);
      start(d, (hold == 0));
      collect(1, hold);
   endtask

   initial begin
      int seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 2'b00;
      out_ready = 1'b1;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      load_defaults();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_score", out_score, 0);
      check("rst_pred", out_pred, 0);

      // XOR truth table with reset weights
      for (int i = 0; i < 4; i++) run_sample(2'(i), 0);

      // W2[2] = 2: sample 11 scores 4
      write_w(8, 2, 0);
      run_sample(2'b11, 0);

      // write during L1 is rejected and leaves the result unchanged
      start(2'b11, 1'b1);
      wr_en   = 1'b1;
      wr_addr = 4'd3;
      wr_data = 8'd50;
      @(negedge clk);
      wr_en = 1'b0;
      check("busy_wr_err", wr_err, 1);
      @(negedge clk);
      check("busy_wr_err_clear", wr_err, 0);
      collect(3, 0);

      // out-of-range address rejected in IDLE
      write_w(12, 77, 1);
      run_sample(2'b11, 0);

      // back-pressure for 5 cycles in DONE
      run_sample(2'b01, 5);

      // reset at E0+4 aborts the computation and restores weights
      start(2'b11, 1'b1);
      void'(sb.pop_back());
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      load_defaults();
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_score", out_score, 0);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("abort_no_valid", seen, 0);
      run_sample(2'b11, 0);
      run_sample(2'b01, 0);

      // negative score
      write_w(6, -5, 0);
      run_sample(2'b00, 0);
      write_w(6, 0, 0);

      // clamp of hidden neuron 0 at 127
      write_w(0, 127, 0);
      write_w(2, 127, 0);
      run_sample(2'b01, 0);
      run_sample(2'b11, 0);

      // weight write in the same cycle as acceptance is used by that computation
      wr_en   = 1'b1;
      wr_addr = 4'd8;
      wr_data = 8'd3;
      wm[8]   = 3;
      start(2'b11, 1'b1);
      wr_en = 1'b0;
      check("same_cycle_wr_err", wr_err, 0);
      collect(1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_nn_sequencer.md
XOR_NN_SEQUENCER -- requirements
Module: xor_nn_sequencer

Interface
REQ-001 Parameter W_W, 8, signed weight width.
REQ-002 Parameter ACC_W, 18, signed accumulator width (ACC_W >= 2*W_W+2).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  input sample offered.
REQ-006 in_data  in  2  sample bits {b,a}.
REQ-007 in_ready  out  1  sequencer can accept a sample.
REQ-008 out_valid  out  1  result available.
REQ-009 out_ready  in  1  consumer takes result.
REQ-010 out_pred  out  1  predicted class.
REQ-011 out_score  out  ACC_W  signed layer-2 sum.
REQ-012 wr_en, wr_addr[3:0], wr_data[W_W-1:0]  in  weight write port.
REQ-013 wr_err  out  1  one-cycle pulse on rejected write.
REQ-014 busy  out  1  high in any state except IDLE.

Function
REQ-015 Network: x = {1, a, b}; h_j = sum_i x_i*W1[i][j] for j=0,1; r_j = clamp(h_j, 0, 127); s = W2[0] + r_0*W2[1] + r_1*W2[2]; out_pred = (s > 0).
REQ-016 Weight map: addr 0..5 = W1[addr>>1][addr&1]; addr 6..8 = W2[addr-6].
REQ-017 Reset weights: W1 = {0,-1, 1,1, 1,1} (addr 0..5); W2 = {0,1,-2}; this set computes XOR.
REQ-018 Single shared MAC: exactly one multiply-add per cycle in compute states.
REQ-019 FSM states: IDLE, L1, L2, DONE.
REQ-020 IDLE: in_ready=1; in_valid&in_ready at edge E0 latches in_data, clears accumulator, enters L1.
REQ-021 L1: 6 cycles, order (i,j) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); after each 3-term neuron, clamped result stored to r_j and accumulator cleared.
REQ-022 L2: 3 cycles, terms W2[0]*1, W2[1]*r_0, W2[2]*r_1.
REQ-023 DONE entered at edge E0+9; out_valid=1 from E0+10 cycle onward (fixed latency 10); out_score, out_pred stable while out_valid=1.
REQ-024 DONE: out_valid&out_ready -> IDLE next edge, out_valid low; in_ready not asserted in same cycle (no bypass, max one sample in flight).
REQ-025 Arithmetic: products sign-extended to ACC_W; no overflow possible at defaults; clamp uses full ACC_W value (negative -> 0, >127 -> 127).
REQ-026 Weight write accepted only in IDLE with wr_addr <= 8, takes effect next edge.
REQ-027 wr_en while busy=1 or wr_addr >= 9: write ignored, wr_err=1 next cycle.
REQ-028 Simultaneous wr_en and accepted sample in IDLE: write applies; the computation uses the new weight.
REQ-029 in_valid in non-IDLE states ignored; in_data need not be held after acceptance.

Reset
REQ-030 On reset: state IDLE, in_ready=1, out_valid=0, out_pred=0, out_score=0, busy=0, wr_err=0, accumulator and r_j = 0, weights per REQ-017.
REQ-031 Reset asserted mid-computation or in DONE aborts it; pending result discarded, no out_valid.

Structure
REQ-032 Shared package xor_nn_pkg holds W_W/ACC_W defaults, state enumeration, weight address constants, default weight values.
REQ-033 One sub-module xor_nn_mac: signed multiply-accumulate with clear and enable, ACC_W result.

Verification
REQ-034 After reset, samples 00,01,10,11 with out_ready=1 -> out_pred 0,1,1,0; out_score 0,1,1,0; out_valid exactly 10 cycles after each acceptance.
REQ-035 Write addr 8 = 2 in IDLE, then sample 11 -> out_score 4, out_pred 1.
REQ-036 wr_en addr 3 during L1 -> wr_err pulse, result unchanged; wr_en addr 12 in IDLE -> wr_err pulse, no weight change.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_score stable, in_ready=0, extra in_valid ignored.
REQ-038 Reset at E0+4 -> IDLE next cycle, no out_valid, weights back to defaults; next sample 01 -> out_pred 1.
REQ-039 Write addr 0 = 127, addr 2 = 127 then sample 01 -> r_0 clamped 127, out_score 127.
